// File: rtl/ascii_cell_averager.sv
// Streams raster pixels, averages each CELL_W x CELL_H cell into a glyph index,
// stores indices in a double-buffered character map, and serves the completed
// frame to the display side through a registered lookup port.
module ascii_cell_averager #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned CELL_W   = 8,
    parameter int unsigned CELL_H   = 8,
    parameter int unsigned PIX_W    = 4,
    parameter int unsigned ROUND    = 0
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             video_on,
    input  logic [PIX_W-1:0] pix_val,
    input  logic [11:0]      pixel_row,
    input  logic [11:0]      pixel_column,
    input  logic             mode_invert,
    output logic             cell_valid,
    output logic [PIX_W-1:0] cell_avg,
    output logic [11:0]      cell_col,
    output logic [11:0]      cell_row,
    output logic             frame_done,
    input  logic [11:0]      rd_row,
    input  logic [11:0]      rd_column,
    output logic [PIX_W-1:0] char_sel
);

    localparam int unsigned LOG_CW = $clog2(CELL_W);
    localparam int unsigned LOG_CH = $clog2(CELL_H);
    localparam int unsigned SHIFT  = LOG_CW + LOG_CH;
    localparam int unsigned SUM_W  = PIX_W + SHIFT;
    localparam int unsigned SUM_W1 = SUM_W + 1;
    localparam int unsigned NUM_CC = H_ACTIVE / CELL_W;
    localparam int unsigned NUM_CR = V_ACTIVE / CELL_H;
    localparam int unsigned CELLS  = NUM_CC * NUM_CR;
    localparam int unsigned MAP_AW = $clog2(2 * CELLS);
    localparam int unsigned ACC_AW = (NUM_CC > 1) ? $clog2(NUM_CC) : 1;

    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [SUM_W:0]   RND_ADD = (ROUND != 0) ? SUM_W1'(1 << (SHIFT - 1)) : '0;

    // Registers
    logic [SUM_W-1:0] hsum_q, hsum_d;
    logic             synced_q, synced_d;
    logic             wr_bank_q, wr_bank_d;
    logic             cell_valid_q, cell_valid_d;
    logic [PIX_W-1:0] cell_avg_q, cell_avg_d;
    logic [11:0]      cell_col_q, cell_col_d;
    logic [11:0]      cell_row_q, cell_row_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] char_sel_q, char_sel_d;

    // Storage (not reset)
    logic [SUM_W-1:0] acc_mem [NUM_CC];
    logic [PIX_W-1:0] map_mem [2*CELLS];

    // Datapath nets
    logic              accept, origin, active;
    logic [11:0]       cx, cy, cc, cr;
    logic              col_last, row_first, row_last, last_cell;
    logic [ACC_AW-1:0] acc_idx;
    logic [SUM_W-1:0]  acc_rd, line_t, cell_sum, acc_wdata;
    logic              acc_we, cell_done;
    logic [SUM_W:0]    rnd_sum, avg_full;
    logic [PIX_W-1:0]  avg_sat, code;
    logic [MAP_AW-1:0] map_waddr, map_raddr;
    logic              rd_ok;

    // Pixel qualification and cell coordinates
    always_comb begin
        accept    = video_on && (pixel_column < 12'(H_ACTIVE)) && (pixel_row < 12'(V_ACTIVE));
        origin    = accept && (pixel_row == 12'd0) && (pixel_column == 12'd0);
        active    = accept && (synced_q || origin);
        cx        = pixel_column & 12'(CELL_W - 1);
        cy        = pixel_row & 12'(CELL_H - 1);
        cc        = pixel_column >> LOG_CW;
        cr        = pixel_row >> LOG_CH;
        col_last  = (cx == 12'(CELL_W - 1));
        row_first = (cy == 12'd0);
        row_last  = (cy == 12'(CELL_H - 1));
        last_cell = (cc == 12'(NUM_CC - 1)) && (cr == 12'(NUM_CR - 1));
        acc_idx   = ACC_AW'(cc);
        acc_rd    = acc_mem[acc_idx];
        line_t    = hsum_q + SUM_W'(pix_val);
    end

    // Horizontal partial sum, accumulator line update and cell completion
    always_comb begin
        hsum_d    = hsum_q;
        synced_d  = synced_q | origin;
        acc_we    = 1'b0;
        acc_wdata = '0;
        cell_done = 1'b0;
        cell_sum  = '0;
        if (active) begin
            if (cx == 12'd0) begin
                hsum_d = SUM_W'(pix_val);
            end else begin
                hsum_d = line_t;
            end
            if (col_last) begin
                if (row_last) begin
                    cell_done = 1'b1;
                    cell_sum  = (CELL_H == 1) ? line_t : acc_rd + line_t;
                end else begin
                    acc_we    = 1'b1;
                    acc_wdata = row_first ? line_t : acc_rd + line_t;
                end
            end
        end
    end

    // Average with optional rounding, saturation and inversion
    always_comb begin
        rnd_sum  = {1'b0, cell_sum} + RND_ADD;
        avg_full = rnd_sum >> SHIFT;
        avg_sat  = (avg_full > SUM_W1'(PIX_MAX)) ? PIX_MAX : avg_full[PIX_W-1:0];
        code     = mode_invert ? ~avg_sat : avg_sat;
    end

    // Result outputs, bank control and map addressing
    always_comb begin
        cell_valid_d = cell_done;
        frame_done_d = cell_done && last_cell;
        cell_avg_d   = cell_done ? code : cell_avg_q;
        cell_col_d   = cell_done ? cc : cell_col_q;
        cell_row_d   = cell_done ? cr : cell_row_q;
        wr_bank_d    = wr_bank_q ^ frame_done_d;
        map_waddr    = (wr_bank_q ? MAP_AW'(CELLS) : '0)
                     + MAP_AW'(cr) * MAP_AW'(NUM_CC) + MAP_AW'(cc);
        rd_ok        = (rd_row < 12'(V_ACTIVE)) && (rd_column < 12'(H_ACTIVE));
        map_raddr    = (wr_bank_q ? '0 : MAP_AW'(CELLS))
                     + MAP_AW'(rd_row >> LOG_CH) * MAP_AW'(NUM_CC)
                     + MAP_AW'(rd_column >> LOG_CW);
        char_sel_d   = rd_ok ? map_mem[map_raddr] : '0;
    end

    // State and output registers
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hsum_q       <= '0;
            synced_q     <= 1'b0;
            wr_bank_q    <= 1'b0;
            cell_valid_q <= 1'b0;
            cell_avg_q   <= '0;
            cell_col_q   <= '0;
            cell_row_q   <= '0;
            frame_done_q <= 1'b0;
            char_sel_q   <= '0;
        end else begin
            hsum_q       <= hsum_d;
            synced_q     <= synced_d;
            wr_bank_q    <= wr_bank_d;
            cell_valid_q <= cell_valid_d;
            cell_avg_q   <= cell_avg_d;
            cell_col_q   <= cell_col_d;
            cell_row_q   <= cell_row_d;
            frame_done_q <= frame_done_d;
            char_sel_q   <= char_sel_d;
        end
    end

    // Accumulator line and character map writes
    always_ff @(posedge vga_clk) begin
        if (acc_we) begin
            acc_mem[acc_idx] <= acc_wdata;
        end
        if (cell_done) begin
            map_mem[map_waddr] <= code;
        end
    end

    assign cell_valid = cell_valid_q;
    assign cell_avg   = cell_avg_q;
    assign cell_col   = cell_col_q;
    assign cell_row   = cell_row_q;
    assign frame_done = frame_done_q;
    assign char_sel   = char_sel_q;

endmodule

// File: tb/tb_ascii_cell_averager.sv
// Randomized bench for ascii_cell_averager with a per-cell sum reference model.
module tb_ascii_cell_averager;

    localparam int H = 64, V = 32, CW = 8, CH = 8;
    localparam int NCC = H / CW, NCR = V / CH, CELLS = NCC * NCR, N = CW * CH;

    logic       vga_clk = 1'b0, reset = 1'b1, video_on = 1'b0, mode_invert = 1'b0;
    logic [3:0] pix_val = '0;
    logic [11:0] pixel_row = '0, pixel_column = '0, rd_row = '0, rd_column = '0;

    logic       cell_valid, frame_done, cell_valid_r1, frame_done_r1;
    logic [3:0] cell_avg, char_sel, cell_avg_r1, char_sel_r1;
    logic [11:0] cell_col, cell_row, cell_col_r1, cell_row_r1;

    ascii_cell_averager #(.H_ACTIVE(H), .V_ACTIVE(V), .CELL_W(CW), .CELL_H(CH),
                          .PIX_W(4), .ROUND(0)) dut (
        .vga_clk(vga_clk), .reset(reset), .video_on(video_on), .pix_val(pix_val),
        .pixel_row(pixel_row), .pixel_column(pixel_column), .mode_invert(mode_invert),
        .cell_valid(cell_valid), .cell_avg(cell_avg), .cell_col(cell_col),
        .cell_row(cell_row), .frame_done(frame_done), .rd_row(rd_row),
        .rd_column(rd_column), .char_sel(char_sel));

    ascii_cell_averager #(.H_ACTIVE(H), .V_ACTIVE(V), .CELL_W(CW), .CELL_H(CH),
                          .PIX_W(4), .ROUND(1)) dut_r1 (
        .vga_clk(vga_clk), .reset(reset), .video_on(video_on), .pix_val(pix_val),
        .pixel_row(pixel_row), .pixel_column(pixel_column), .mode_invert(mode_invert),
        .cell_valid(cell_valid_r1), .cell_avg(cell_avg_r1), .cell_col(cell_col_r1),
        .cell_row(cell_row_r1), .frame_done(frame_done_r1), .rd_row(rd_row),
        .rd_column(rd_column), .char_sel(char_sel_r1));

    always #5 vga_clk = ~vga_clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain per-cell sums, two map banks with written flags
    int  m_sum [CELLS];
    int  m_map [2][CELLS];
    bit  m_wr  [2][CELLS];
    bit  m_synced, m_bank;
    bit  exp_valid, exp_fd, exp_char_known;
    int  exp_avg, exp_avg1, exp_col, exp_row, exp_char;

    always @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            m_synced = 0; m_bank = 0;
            exp_valid = 0; exp_fd = 0; exp_avg = 0; exp_avg1 = 0;
            exp_col = 0; exp_row = 0; exp_char = 0; exp_char_known = 1;
        end else begin : step
            int r, c, k, a0, a1;
            if (int'(rd_row) < V && int'(rd_column) < H) begin
                k = (int'(rd_row) / CH) * NCC + int'(rd_column) / CW;
                exp_char_known = m_wr[!m_bank][k];
                exp_char = m_map[!m_bank][k];
            end else begin
                exp_char_known = 1; exp_char = 0;
            end
            exp_valid = 0; exp_fd = 0;
            r = int'(pixel_row); c = int'(pixel_column);
            if (video_on && r < V && c < H) begin
                if (r == 0 && c == 0) m_synced = 1;
                if (m_synced) begin
                    k = (r / CH) * NCC + c / CW;
                    if (r % CH == 0 && c % CW == 0) m_sum[k] = 0;
                    m_sum[k] += int'(pix_val);
                    if (r % CH == CH - 1 && c % CW == CW - 1) begin
                        a0 = m_sum[k] / N;
                        a1 = (m_sum[k] + N / 2) / N;
                        if (a1 > 15) a1 = 15;
                        if (mode_invert) begin a0 = 15 - a0; a1 = 15 - a1; end
                        exp_valid = 1; exp_avg = a0; exp_avg1 = a1;
                        exp_col = c / CW; exp_row = r / CH;
                        m_map[m_bank][k] = a0; m_wr[m_bank][k] = 1;
                        if (k == CELLS - 1) begin exp_fd = 1; m_bank = !m_bank; end
                    end
                end
            end
        end
    end

    // Per-cycle compare plus bookkeeping for the literal checks
    int valid_cnt = 0, fd_cnt = 0, last_avg = -1;
    int cap00 = -1, cap00_r1 = -1, cap10 = -1, cap10_r1 = -1, cap_mid = -1;
    bit cap_en = 0;

    always @(negedge vga_clk) begin
        chk("cell_valid", int'(cell_valid), int'(exp_valid));
        chk("frame_done", int'(frame_done), int'(exp_fd));
        chk("cell_valid_r1", int'(cell_valid_r1), int'(exp_valid));
        if (exp_valid) begin
            chk("cell_avg", int'(cell_avg), exp_avg);
            chk("cell_avg_r1", int'(cell_avg_r1), exp_avg1);
            chk("cell_col", int'(cell_col), exp_col);
            chk("cell_row", int'(cell_row), exp_row);
        end
        if (exp_char_known) chk("char_sel", int'(char_sel), exp_char);
        if (cell_valid) begin
            valid_cnt++;
            last_avg = int'(cell_avg);
            if (cell_col == 0 && cell_row == 0) cap00 = int'(cell_avg);
            if (cell_col == 1 && cell_row == 0) cap10 = int'(cell_avg);
        end
        if (cell_valid_r1) begin
            if (cell_col_r1 == 0 && cell_row_r1 == 0) cap00_r1 = int'(cell_avg_r1);
            if (cell_col_r1 == 1 && cell_row_r1 == 0) cap10_r1 = int'(cell_avg_r1);
        end
        if (frame_done) fd_cnt++;
        if (cap_en && video_on && pixel_row == 12'd16 && pixel_column == 12'd0)
            cap_mid = int'(char_sel);
    end

    // Stimulus
    bit rd_fixed = 0;
    int rd_r = 0, rd_c = 0, inv_mode = 0;

    task automatic cyc(input bit vo, input int p, input int r, input int c);
        @(posedge vga_clk); #2;
        video_on = vo; pix_val = 4'(p);
        pixel_row = 12'(r); pixel_column = 12'(c);
        mode_invert = (inv_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(inv_mode);
        if (rd_fixed) begin
            rd_row = 12'(rd_r); rd_column = 12'(rd_c);
        end else begin
            rd_row = 12'($urandom_range(0, V + 3)); rd_column = 12'($urandom_range(0, H + 9));
        end
    endtask

    function automatic int pix_of(input int mode, input int cval, input int r, input int c);
        if (mode == 0) return cval;
        if (mode == 2 && r < CH && c < CW) return (r == 3 && c == 2) ? 0 : 15;
        if (mode == 2 && r < CH && c < 2 * CW) return 15;
        return int'($urandom_range(0, 15));
    endfunction

    task automatic mid_reset();
        @(posedge vga_clk); #3;
        reset = 1; video_on = 0;
        #1;
        chk("async_rst_valid", int'(cell_valid), 0);
        chk("async_rst_fd", int'(frame_done), 0);
        chk("async_rst_avg", int'(cell_avg), 0);
        chk("async_rst_col", int'(cell_col), 0);
        chk("async_rst_row", int'(cell_row), 0);
        chk("async_rst_char", int'(char_sel), 0);
        @(posedge vga_clk); #2;
        reset = 0;
    endtask

    task automatic run_frame(input int mode, input int cval, input int start_row,
                             input bit gaps, input int reset_row);
        for (int r = start_row; r < V + 2; r++) begin
            for (int c = 0; c < H + 8; c++) begin
                if (r == reset_row && c == 0) mid_reset();
                if (r < V && c < H) begin
                    if (gaps && $urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 2)) cyc(1'b0, 15, r, c);
                    cyc(1'b1, pix_of(mode, cval, r, c), r, c);
                end else begin
                    cyc($urandom_range(0, 3) == 0, 15, r, c);
                end
            end
        end
    endtask

    task automatic rd_check(input string nm, input int r, input int c, input int exp);
        rd_fixed = 1; rd_r = r; rd_c = c;
        cyc(1'b0, 0, V + 1, H + 1);
        @(posedge vga_clk); #1;
        chk(nm, int'(char_sel), exp);
    endtask

    int v0, f0;

    initial begin
        repeat (3) @(posedge vga_clk);
        #2;
        chk("rst_valid", int'(cell_valid), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_avg", int'(cell_avg), 0);
        chk("rst_col", int'(cell_col), 0);
        chk("rst_row", int'(cell_row), 0);
        chk("rst_char", int'(char_sel), 0);
        reset = 0;

        // Partial frame without (0,0): nothing may happen
        v0 = valid_cnt; f0 = fd_cnt;
        run_frame(1, 0, 5, 1'b0, -1);
        chk("unsynced_valids", valid_cnt - v0, 0);
        chk("unsynced_fd", fd_cnt - f0, 0);

        // Two constant-10 frames
        for (int f = 0; f < 2; f++) begin
            v0 = valid_cnt; f0 = fd_cnt;
            run_frame(0, 10, 0, 1'b0, -1);
            chk("const10_valids", valid_cnt - v0, CELLS);
            chk("const10_fd", fd_cnt - f0, 1);
            chk("const10_avg", last_avg, 10);
        end
        rd_check("const10_rd_a", 3, 5, 10);
        rd_check("const10_rd_b", V - 1, H - 1, 10);
        rd_fixed = 0;

        // Cell (0,0): 63 x 15 plus one 0; cell (1,0): all 15
        run_frame(2, 0, 0, 1'b0, -1);
        chk("cell00_trunc", cap00, 14);
        chk("cell00_round", cap00_r1, 15);
        chk("cell10_all15", cap10, 15);
        chk("cell10_all15_round", cap10_r1, 15);

        // Inverted constant 3
        inv_mode = 1;
        run_frame(0, 3, 0, 1'b0, -1);
        chk("invert3_avg", last_avg, 12);

        // Random pixels, per-cycle random invert, gaps
        inv_mode = 2;
        run_frame(1, 0, 0, 1'b1, -1);
        inv_mode = 0;

        // Frame A = 5, frame B = 9, fixed lookup during B
        run_frame(0, 5, 0, 1'b0, -1);
        rd_fixed = 1; rd_r = 17; rd_c = 40; cap_en = 1;
        run_frame(0, 9, 0, 1'b0, -1);
        cap_en = 0;
        chk("bankA_during_B", cap_mid, 5);
        rd_check("bankB_after", 17, 40, 9);
        rd_check("rd_out_of_range", 17, 700, 0);
        rd_fixed = 0;

        // Reset at row 10, then one clean frame
        run_frame(1, 0, 0, 1'b0, 10);
        v0 = valid_cnt; f0 = fd_cnt;
        run_frame(1, 0, 0, 1'b0, -1);
        chk("post_reset_valids", valid_cnt - v0, CELLS);
        chk("post_reset_fd", fd_cnt - f0, 1);

        // All-2 frame with gaps carrying 15
        v0 = valid_cnt;
        run_frame(0, 2, 0, 1'b1, -1);
        chk("gap_frame_valids", valid_cnt - v0, CELLS);
        chk("gap_frame_avg", last_avg, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
